branch_resolver: RTL
====================

# branch_resolver

Out-of-order branch resolution queue in the execute side of the core. It accepts branches and register jumps from ID whose outcome or target was left undetermined because an operand was still an RSID. It captures the missing operands from the common data bus and resolves entries strictly in program order. For each entry it reports taken/not-taken, and on a misprediction it issues a redirect PC and drops every younger pending entry.

## Interface
Parameters:
- DEPTH, 4: queue entries (power of two, ≥2)
- RSID_WIDTH, 4: reservation-station ID width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  external pipeline flush (exception/eret); clears queue
- in_valid  in  1  enqueue request from ID
- in_ready  out  1  queue can accept (count < DEPTH)
- in_kind  in  3  0 EQ, 1 NE, 2 GTZ, 3 LEZ, 4 LTZ, 5 GEZ, 6 JR (covers JR/JALR); 7 reserved (treated as JR)
- in_pred_taken  in  1  direction predicted by front end
- in_target  in  32  branch target (kind 0-5) or predicted jump target (kind 6)
- in_fallthrough  in  32  PC after delay slot (pc+8)
- in_src1_is_rsid, in_src2_is_rsid  in  1 each  operand pending
- in_src1, in_src2  in  32 each  value, or RSID in low RSID_WIDTH bits when pending
- cdb_valid  in  1  CDB broadcast valid
- cdb_rsid  in  RSID_WIDTH  producing RSID
- cdb_data  in  32  produced value
- resolve_valid  out  1  one-cycle pulse: head entry resolved
- resolve_taken  out  1  actual direction
- resolve_mispredict  out  1  direction or target wrong
- redirect_pc  out  32  correct next PC (valid when resolve_mispredict)

## Operation
- Circular FIFO with head/tail pointers and a count of width log2(DEPTH)+1. Each entry holds kind, pred_taken, target, fallthrough, and for each operand a ready bit and 32-bit value.
- Enqueue when in_valid && in_ready. An operand with is_rsid=0 is stored ready. A pending operand is stored as not ready with its tag.
- CDB snoop every cycle: each valid, not-ready operand whose tag equals cdb_rsid captures cdb_data and sets ready. The snoop also applies to the entry being enqueued in the same cycle (bypass).
- src2 is ignored (treated ready) for kinds 2-6.
- Condition evaluation (signed 32-bit):
  - EQ: a==b; NE: a!=b
  - GTZ: !a[31] && a!=0; LEZ: a[31] || a==0
  - LTZ: a[31]; GEZ: !a[31]
  - JR: always taken
- Resolution acts only on the head entry, once all of its required operands are ready in storage. An operand captured this cycle is used next cycle.
- Branch mispredict when taken != pred_taken. redirect_pc = taken ? target : fallthrough.
- JR mispredict when !pred_taken or src1 != target. redirect_pc = src1.
- Resolved head is dequeued. On mispredict, the whole queue is cleared (all entries are younger), and any enqueue in the same cycle is dropped.
- Priority: rst > flush > mispredict clear > normal enqueue/dequeue. A flush in the same cycle as a resolution suppresses the resolve outputs next cycle.
- Simultaneous enqueue and dequeue with no mispredict: count unchanged, both pointers advance modulo DEPTH.

## Timing
- Reset: queue empty, in_ready=1, resolve_valid=0, resolve_taken=0, resolve_mispredict=0, redirect_pc=0.
- in_ready is combinational from count only. A full queue stays not ready even if a dequeue happens that cycle.
- All resolve_* and redirect_pc outputs are registered.
  - Head with operands ready at cycle N: outputs valid at cycle N+1, for one cycle.
  - resolve_* and redirect_pc return to 0 when resolve_valid=0.
- Throughput: one resolution per cycle.
- Latency from enqueue of a fully ready entry at an empty head (edge E): resolve_valid in the cycle after E+1.
- Latency from a CDB capture at edge C: resolution evaluated in cycle C+1, outputs in cycle C+2.
- After a mispredict or flush, the queue is empty and in_ready=1 on the next cycle.
- Pointer wrap: tail and head wrap DEPTH-1 → 0 with no bubble.

## Test plan
- Reset, then enqueue BEQ with both operands ready (5,5), pred_taken=0, target=0x1000, fallthrough=0x208 → resolve_valid=1, taken=1, mispredict=1, redirect_pc=0x1000; queue empty afterwards.
- BNE with src1 pending tag 3; cdb (3, 0x7) two cycles later; src2=7 → no resolve before capture; resolve taken=0, mispredict=0 exactly two cycles after the capture cycle.
- Fill 4 entries, all src1 pending on tag 2 → in_ready=0. One CDB broadcast of tag 2 → four in-order resolve pulses on consecutive cycles, with in_ready rising as entries retire.
- Second of three entries mispredicts (BGEZ, src1=0xFFFFFFFF, pred_taken=1) → first resolves normally, second gives redirect_pc=fallthrough, third never resolves, and a same-cycle enqueue is dropped.
- JR with src1 pending, predicted target 0x400; CDB delivers 0x404 in the same cycle as enqueue → captured via bypass; mispredict=1, redirect_pc=0x404.
- flush asserted while two entries are waiting and a head resolution is in flight → no resolve_valid next cycle, queue empty, in_ready=1; wrap-around pointers verified by 6 subsequent ready enqueues.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Bundles the ID enqueue port, CDB snoop port and resolve outputs of the branch resolver.
// No logic here; timing is that of the attached resolver.
// in_ready is the only backpressure signal; CDB and resolve outputs have none.
interface branch_resolver_if #(
  parameter int RSID_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_kind;
  logic                  in_pred_taken;
  logic [31:0]           in_target;
  logic [31:0]           in_fallthrough;
  logic                  in_src1_is_rsid;
  logic                  in_src2_is_rsid;
  logic [31:0]           in_src1;
  logic [31:0]           in_src2;
  logic                  cdb_valid;
  logic [RSID_WIDTH-1:0] cdb_rsid;
  logic [31:0]           cdb_data;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic                  resolve_mispredict;
  logic [31:0]           redirect_pc;

  modport master (
    output in_valid, in_kind, in_pred_taken, in_target, in_fallthrough,
           in_src1_is_rsid, in_src2_is_rsid, in_src1, in_src2,
           cdb_valid, cdb_rsid, cdb_data,
    input  in_ready, resolve_valid, resolve_taken, resolve_mispredict, redirect_pc
  );

  modport slave (
    input  in_valid, in_kind, in_pred_taken, in_target, in_fallthrough,
           in_src1_is_rsid, in_src2_is_rsid, in_src1, in_src2,
           cdb_valid, cdb_rsid, cdb_data,
    output in_ready, resolve_valid, resolve_taken, resolve_mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order branch/JR resolution queue; pending operands are captured from the CDB.
// Resolve outputs registered: one cycle after the head has all operands ready in storage.
// in_ready = count < DEPTH (combinational from count only); resolve side has no backpressure.
module branch_resolver #(
  parameter int DEPTH      = 4,
  parameter int RSID_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  input logic flush,
  branch_resolver_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  // Entry storage; a pending operand keeps its RSID tag in the low bits of its value.
  logic [2:0]  e_kind   [DEPTH];
  logic        e_pred   [DEPTH];
  logic [31:0] e_target [DEPTH];
  logic [31:0] e_fall   [DEPTH];
  logic [31:0] e_a      [DEPTH];
  logic [31:0] e_b      [DEPTH];
  logic        e_a_rdy  [DEPTH];
  logic        e_b_rdy  [DEPTH];
  logic        e_vld    [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic        enq, do_res, clr;
  logic [2:0]  h_kind;
  logic [31:0] a, b;
  logic        need_b, cond, taken, mispred;
  logic [31:0] redir;
  logic        a_hit, b_hit;

  logic        res_vld, res_taken, res_mispred;
  logic [31:0] res_pc;

  assign bus.in_ready = (count < (PW+1)'(DEPTH));
  assign enq = bus.in_valid && bus.in_ready;

  // Same-cycle CDB bypass for the operands being enqueued.
  assign a_hit = bus.in_src1_is_rsid && bus.cdb_valid && (bus.in_src1[RSID_WIDTH-1:0] == bus.cdb_rsid);
  assign b_hit = bus.in_src2_is_rsid && bus.cdb_valid && (bus.in_src2[RSID_WIDTH-1:0] == bus.cdb_rsid);

  // Evaluate the head entry from stored (registered) operands only.
  always_comb begin
    h_kind  = e_kind[head];
    a       = e_a[head];
    b       = e_b[head];
    need_b  = (h_kind < 3'd2);
    do_res  = (count != '0) && e_a_rdy[head] && (!need_b || e_b_rdy[head]);
    cond    = 1'b1;
    case (h_kind)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd2:    cond = !a[31] && (a != 32'd0);
      3'd3:    cond = a[31] || (a == 32'd0);
      3'd4:    cond = a[31];
      3'd5:    cond = !a[31];
      default: cond = 1'b1;
    endcase
    taken = cond;
    if (h_kind >= 3'd6) begin
      mispred = !e_pred[head] || (a != e_target[head]);
      redir   = a;
    end else begin
      mispred = (cond != e_pred[head]);
      redir   = cond ? e_target[head] : e_fall[head];
    end
    clr = flush || (do_res && mispred);
  end

  // Queue control: pointers, count and entry-valid bits; a clear drops any same-cycle enqueue.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) e_vld[i] <= 1'b0;
    end else begin
      if (enq) begin
        e_vld[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (do_res) begin
        e_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({enq, do_res})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload: CDB snoop on waiting operands, then the enqueue write at tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.cdb_valid && e_vld[i] && !e_a_rdy[i] && (e_a[i][RSID_WIDTH-1:0] == bus.cdb_rsid)) begin
        e_a[i]     <= bus.cdb_data;
        e_a_rdy[i] <= 1'b1;
      end
      if (bus.cdb_valid && e_vld[i] && !e_b_rdy[i] && (e_b[i][RSID_WIDTH-1:0] == bus.cdb_rsid)) begin
        e_b[i]     <= bus.cdb_data;
        e_b_rdy[i] <= 1'b1;
      end
    end
    if (enq) begin
      e_kind[tail]   <= bus.in_kind;
      e_pred[tail]   <= bus.in_pred_taken;
      e_target[tail] <= bus.in_target;
      e_fall[tail]   <= bus.in_fallthrough;
      e_a[tail]      <= a_hit ? bus.cdb_data : bus.in_src1;
      e_b[tail]      <= b_hit ? bus.cdb_data : bus.in_src2;
      e_a_rdy[tail]  <= !bus.in_src1_is_rsid || a_hit;
      e_b_rdy[tail]  <= !bus.in_src2_is_rsid || b_hit;
    end
  end

  // Registered resolve outputs; zero when idle, and a same-cycle flush suppresses them.
  always_ff @(posedge clk) begin
    if (rst || flush || !do_res) begin
      res_vld     <= 1'b0;
      res_taken   <= 1'b0;
      res_mispred <= 1'b0;
      res_pc      <= 32'd0;
    end else begin
      res_vld     <= 1'b1;
      res_taken   <= taken;
      res_mispred <= mispred;
      res_pc      <= redir;
    end
  end

  assign bus.resolve_valid      = res_vld;
  assign bus.resolve_taken      = res_taken;
  assign bus.resolve_mispredict = res_mispred;
  assign bus.redirect_pc        = res_pc;
endmodule
